// File: rtl/result_encoder.sv
// rtl/result_encoder.sv - re-assembles skewed per-column array results into row-aligned BRAM words
module result_encoder #(
    parameter int REG_WIDTH   = 16,
    parameter int MATRIX_SIZE = 4,
    parameter int BRAM_DEPTH  = MATRIX_SIZE * REG_WIDTH,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [MATRIX_SIZE-1:0] col_valid,
    input  logic [BRAM_DEPTH-1:0]  col_data,
    output logic                   bram_we,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [BRAM_DEPTH-1:0]  bram_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    // CW holds 0..MATRIX_SIZE so a lane counter can sit at "full"; IW indexes a row
    localparam int CW = $clog2(MATRIX_SIZE + 1);
    localparam int IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [CW-1:0] ROWS_C = CW'(MATRIX_SIZE);
    localparam logic [CW-1:0] LAST_C = CW'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [REG_WIDTH-1:0]   row_buf  [MATRIX_SIZE][MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0] row_mask [MATRIX_SIZE];
    logic [CW-1:0]          lane_row [MATRIX_SIZE];
    logic [CW-1:0]          wr_row;
    logic [IW-1:0]          wr_idx;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic                   wr_fire;
    logic [BRAM_DEPTH-1:0]  wr_word;

    assign wr_idx = wr_row[IW-1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start always (re)enters COLLECT; the write of the last row ends it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = COLLECT;
            end
            COLLECT: begin
                if (start) begin
                    state_next = COLLECT;
                end else if (wr_fire && (wr_row == LAST_C)) begin
                    state_next = DONE_ST;
                end
            end
            DONE_ST: begin
                state_next = start ? COLLECT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs and write decision: the oldest unwritten row drains once every lane has filled it
    always_comb begin
        busy    = (state == COLLECT);
        wr_fire = 1'b0;
        wr_word = '0;
        if ((state == COLLECT) && !start && (wr_row < ROWS_C)) begin
            wr_fire = &row_mask[wr_idx];
        end
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            wr_word[j*REG_WIDTH +: REG_WIDTH] = row_buf[wr_idx][j];
        end
    end

    // Datapath: lane capture, row masks, write port registers and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            base_q     <= '0;
            wr_row     <= '0;
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                row_mask[r] <= '0;
                lane_row[r] <= '0;
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    row_buf[r][j] <= '0;
                end
            end
        end else begin
            bram_we <= 1'b0;
            done    <= (state == DONE_ST);
            if (start) begin
                // New matrix (or abort of the current one): samples this cycle are discarded
                base_q   <= base_addr;
                wr_row   <= '0;
                overflow <= 1'b0;
                for (int r = 0; r < MATRIX_SIZE; r++) begin
                    row_mask[r] <= '0;
                    lane_row[r] <= '0;
                end
            end else if (state == COLLECT) begin
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    if (col_valid[j]) begin
                        if (lane_row[j] < ROWS_C) begin
                            row_buf[lane_row[j][IW-1:0]][j]  <= col_data[j*REG_WIDTH +: REG_WIDTH];
                            row_mask[lane_row[j][IW-1:0]][j] <= 1'b1;
                            lane_row[j]                      <= lane_row[j] + CW'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                if (wr_fire) begin
                    bram_we    <= 1'b1;
                    bram_addr  <= base_q + ADDR_WIDTH'(wr_row);
                    bram_wdata <= wr_word;
                    wr_row     <= wr_row + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_result_encoder.sv
// tb/tb_result_encoder.sv - scoreboard bench for result_encoder
module tb_result_encoder;

    localparam int RW = 16;
    localparam int MS = 4;
    localparam int BD = MS * RW;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [MS-1:0] col_valid = '0;
    logic [BD-1:0] col_data = '0;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [BD-1:0] bram_wdata;
    logic          busy;
    logic          done;
    logic          overflow;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BD-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  passed = 0;
    int  failed = 0;
    int  total = 0;
    int  lane_cnt[MS];

    always #5 clk = ~clk;

    result_encoder #(
        .REG_WIDTH(RW),
        .MATRIX_SIZE(MS),
        .BRAM_DEPTH(BD),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .col_valid(col_valid),
        .col_data(col_data),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_wdata(bram_wdata),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int r, input int j, input int salt);
        return RW'((r << 8) | (j << 4) | salt);
    endfunction

    function automatic logic [BD-1:0] row_word(input int r, input int salt);
        logic [BD-1:0] w;
        w = '0;
        for (int j = 0; j < MS; j++) w[j*RW +: RW] = mk(r, j, salt);
        return w;
    endfunction

    task automatic push_row(input logic [AW-1:0] b, input int r, input int salt);
        wr_t e;
        e.addr = AW'(b + AW'(r));
        e.data = row_word(r, salt);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [MS-1:0] v, input int salt);
        col_valid = v;
        col_data  = '0;
        for (int j = 0; j < MS; j++) begin
            if (v[j]) begin
                col_data[j*RW +: RW] = mk(lane_cnt[j], j, salt);
                lane_cnt[j]++;
            end
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        col_valid = '0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < MS; j++) lane_cnt[j] = 0;
    endtask

    // Scoreboard: every write strobe must match the oldest expected row
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("bram_addr", 64'(bram_addr), 64'(e.addr));
                check("bram_wdata", bram_wdata, e.data);
            end
        end
    end

    initial begin
        wr_t e0;
        logic [MS-1:0] v;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", 64'(bram_we), 0);
        check("rst_addr", 64'(bram_addr), 0);
        check("rst_wdata", bram_wdata, 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_ovf", 64'(overflow), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: skewed stream, lane j valid on cycles j..j+3
        do_start(8'h10);
        check("t1_busy_start", 64'(busy), 1);
        e0.addr = 8'h10;
        e0.data = 64'h0030_0020_0010_0000;
        exp_q.push_back(e0);
        for (int r = 1; r < MS; r++) push_row(8'h10, r, 0);
        for (int t = 0; t < 10; t++) begin
            for (int j = 0; j < MS; j++) v[j] = (t >= j) && (t <= j + 3);
            drive(v, 0);
            @(negedge clk);
            check($sformatf("t1_we_%0d", t), 64'(bram_we), 64'((t >= 4) && (t <= 7)));
            check($sformatf("t1_busy_%0d", t), 64'(busy), 64'(t < 7));
            check($sformatf("t1_done_%0d", t), 64'(done), 64'(t == 8));
        end

        // 2: all lanes together, one write per cycle, one cycle after each row
        do_start(8'h00);
        for (int r = 0; r < MS; r++) push_row(8'h00, r, 5);
        for (int t = 0; t < 7; t++) begin
            drive((t < 4) ? 4'hF : 4'h0, 5);
            @(negedge clk);
            check($sformatf("t2_we_%0d", t), 64'(bram_we), 64'((t >= 1) && (t <= 4)));
            check($sformatf("t2_done_%0d", t), 64'(done), 64'(t == 5));
        end

        // 3: lane 0 sends a fifth sample
        do_start(8'h30);
        for (int r = 0; r < MS; r++) push_row(8'h30, r, 10);
        for (int t = 0; t < 8; t++) begin
            drive((t < 4) ? 4'hF : ((t == 4) ? 4'h1 : 4'h0), 10);
            @(negedge clk);
            check($sformatf("t3_we_%0d", t), 64'(bram_we), 64'((t >= 1) && (t <= 4)));
            check($sformatf("t3_ovf_%0d", t), 64'(overflow), 64'(t >= 4));
        end

        // 4: address wrap from 0xFE; start also clears the sticky overflow
        do_start(8'hFE);
        check("t4_ovf_cleared", 64'(overflow), 0);
        for (int r = 0; r < MS; r++) push_row(8'hFE, r, 7);
        for (int t = 0; t < 7; t++) begin
            drive((t < 4) ? 4'hF : 4'h0, 7);
            @(negedge clk);
            check($sformatf("t4_we_%0d", t), 64'(bram_we), 64'((t >= 1) && (t <= 4)));
        end

        // 5: restart after rows 0-1; samples in the restart cycle are ignored
        do_start(8'h40);
        push_row(8'h40, 0, 1);
        push_row(8'h40, 1, 1);
        for (int t = 0; t < 5; t++) begin
            drive((t < 2) ? 4'hF : ((t < 4) ? 4'h7 : 4'h0), 1);
            @(negedge clk);
            check($sformatf("t5a_we_%0d", t), 64'(bram_we), 64'((t >= 1) && (t <= 2)));
        end
        start     = 1'b1;
        base_addr = 8'h80;
        drive(4'hF, 1);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < MS; j++) lane_cnt[j] = 0;
        check("t5_we_restart", 64'(bram_we), 0);
        check("t5_busy_restart", 64'(busy), 1);
        for (int r = 0; r < MS; r++) push_row(8'h80, r, 2);
        for (int t = 0; t < 7; t++) begin
            drive((t < 4) ? 4'hF : 4'h0, 2);
            @(negedge clk);
            check($sformatf("t5b_we_%0d", t), 64'(bram_we), 64'((t >= 1) && (t <= 4)));
            check($sformatf("t5b_done_%0d", t), 64'(done), 64'(t == 5));
        end

        // 6: asynchronous reset mid-COLLECT, then samples without start
        do_start(8'h20);
        push_row(8'h20, 0, 12);
        drive(4'hF, 12);
        @(negedge clk);
        drive(4'hF, 12);
        @(negedge clk);
        check("t6_we_before_rst", 64'(bram_we), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_we", 64'(bram_we), 0);
        check("t6_rst_addr", 64'(bram_addr), 0);
        check("t6_rst_wdata", bram_wdata, 0);
        check("t6_rst_busy", 64'(busy), 0);
        check("t6_rst_done", 64'(done), 0);
        check("t6_rst_ovf", 64'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 6; t++) begin
            drive(4'hF, 12);
            @(negedge clk);
            check($sformatf("t6_no_we_%0d", t), 64'(bram_we), 0);
            check($sformatf("t6_idle_busy_%0d", t), 64'(busy), 0);
        end
        col_valid = '0;
        @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
